// File: rtl/gpio_edge_irq_pkg.sv
// gpio_edge_irq_pkg
// Shared GembSoC IO constants for the GPIO edge-interrupt block: default data
// width, default base address, register offsets, the DebounceCount reset value
// and a helper that maps an in-window offset onto a register select.
package gpio_edge_irq_pkg;

  localparam int unsigned GPIO_DATA_SIZE    = 8;
  localparam int unsigned GPIO_BASE_ADDRESS = 60003;
  localparam int unsigned GPIO_NUM_REGS     = 5;
  localparam int unsigned GPIO_DEBOUNCE_RST = 4;

  localparam logic [2:0] OFF_STATUS   = 3'd0;
  localparam logic [2:0] OFF_ENABLE   = 3'd1;
  localparam logic [2:0] OFF_EDGESEL  = 3'd2;
  localparam logic [2:0] OFF_DEBOUNCE = 3'd3;
  localparam logic [2:0] OFF_LEVEL    = 3'd4;

  typedef enum logic [2:0] {
    SEL_STATUS,
    SEL_ENABLE,
    SEL_EDGESEL,
    SEL_DEBOUNCE,
    SEL_LEVEL,
    SEL_NONE
  } reg_sel_e;

  function automatic reg_sel_e decode_reg(input logic [2:0] off);
    case (off)
      OFF_STATUS:   return SEL_STATUS;
      OFF_ENABLE:   return SEL_ENABLE;
      OFF_EDGESEL:  return SEL_EDGESEL;
      OFF_DEBOUNCE: return SEL_DEBOUNCE;
      OFF_LEVEL:    return SEL_LEVEL;
      default:      return SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/gpio_edge_irq_debounce_bit.sv
// gpio_debounce_bit
// One GPIO pin: 2-flop synchronizer, debounce counter and committed level.
// Ports:
//   clk, reset_n  system clock / async active-low reset
//   pin_i         raw asynchronous pin level
//   dcount_i      debounce compare value (0 = bypass, one cycle after sync2)
//   level_o       debounced level
//   rise_o        pulse on the cycle a 0->1 commit happens (before the edge)
//   fall_o        pulse on the cycle a 1->0 commit happens (before the edge)
module gpio_debounce_bit #(
  parameter int unsigned CntW = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            pin_i,
  input  logic [CntW-1:0] dcount_i,
  output logic            level_o,
  output logic            rise_o,
  output logic            fall_o
);

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            commit;

  // Equality compare only: a counter already past a newly lowered dcount_i
  // runs on and commits after wrapping round to it.
  assign commit = (sync2_q != level_q) && (cnt_q == dcount_i);

  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (commit) begin
      level_d = sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= pin_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = commit & sync2_q;
  assign fall_o  = commit & ~sync2_q;

endmodule

// File: rtl/gpio_edge_irq.sv
// gpio_edge_irq
// GPIO port with per-pin debounce, edge latching and a registered interrupt.
// Registers (from BaseAddress): +0 Status (W1C), +1 Enable, +2 EdgeSel
// (1 = rising), +3 DebounceCount, +4 Level (read-only).
// Ports:
//   clk, reset_n  system clock / async active-low reset
//   Addr          bus address (2*DataSize bits)
//   r_w           0 = read (block drives Data), 1 = write
//   write         one-cycle write strobe
//   Data          bidirectional bus data, high-Z unless a mapped read
//   PinIn         raw asynchronous pin levels
//   IRQ           registered OR of (Status & Enable)
module gpio_edge_irq
  import gpio_edge_irq_pkg::*;
#(
  parameter int unsigned DataSize    = GPIO_DATA_SIZE,
  parameter int unsigned BaseAddress = GPIO_BASE_ADDRESS
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2*DataSize-1:0] Addr,
  input  logic                  r_w,
  input  logic                  write,
  inout  wire  [DataSize-1:0]   Data,
  input  logic [DataSize-1:0]   PinIn,
  output logic                  IRQ
);

  localparam int unsigned AddrW = 2 * DataSize;
  localparam logic [AddrW-1:0] BaseA = AddrW'(BaseAddress);

  logic [DataSize-1:0] status_q, status_d;
  logic [DataSize-1:0] enable_q, enable_d;
  logic [DataSize-1:0] edgesel_q, edgesel_d;
  logic [DataSize-1:0] dcount_q, dcount_d;
  logic                irq_q, irq_d;

  logic [DataSize-1:0] level, rise, fall, set_evt, status_clr, rdata;
  logic [AddrW-1:0]    offset;
  logic                in_window, rd_en;
  reg_sel_e            sel;

  assign offset    = Addr - BaseA;
  assign in_window = (Addr >= BaseA) && (offset < AddrW'(GPIO_NUM_REGS));
  assign sel       = in_window ? decode_reg(offset[2:0]) : SEL_NONE;

  for (genvar i = 0; i < DataSize; i++) begin : g_bit
    gpio_debounce_bit #(.CntW(DataSize)) u_bit (
      .clk      (clk),
      .reset_n  (reset_n),
      .pin_i    (PinIn[i]),
      .dcount_i (dcount_q),
      .level_o  (level[i]),
      .rise_o   (rise[i]),
      .fall_o   (fall[i])
    );
  end

  // EdgeSel is sampled at commit time only, so changing it never touches Status.
  assign set_evt = (rise & edgesel_q) | (fall & ~edgesel_q);

  always_comb begin
    status_clr = '0;
    enable_d   = enable_q;
    edgesel_d  = edgesel_q;
    dcount_d   = dcount_q;
    if (write && r_w) begin
      case (sel)
        SEL_STATUS:   status_clr = Data;
        SEL_ENABLE:   enable_d   = Data;
        SEL_EDGESEL:  edgesel_d  = Data;
        SEL_DEBOUNCE: dcount_d   = Data;
        default:      ;
      endcase
    end
    // A new event wins over a W1C in the same cycle.
    status_d = (status_q & ~status_clr) | set_evt;
    irq_d    = |(status_q & enable_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      status_q  <= '0;
      enable_q  <= '0;
      edgesel_q <= '0;
      dcount_q  <= DataSize'(GPIO_DEBOUNCE_RST);
      irq_q     <= 1'b0;
    end else begin
      status_q  <= status_d;
      enable_q  <= enable_d;
      edgesel_q <= edgesel_d;
      dcount_q  <= dcount_d;
      irq_q     <= irq_d;
    end
  end

  always_comb begin
    rdata = '0;
    case (sel)
      SEL_STATUS:   rdata = status_q;
      SEL_ENABLE:   rdata = enable_q;
      SEL_EDGESEL:  rdata = edgesel_q;
      SEL_DEBOUNCE: rdata = dcount_q;
      SEL_LEVEL:    rdata = level;
      default:      rdata = '0;
    endcase
  end

  assign rd_en = !r_w && (sel != SEL_NONE);
  assign Data  = rd_en ? rdata : {DataSize{1'bz}};
  assign IRQ   = irq_q;

endmodule

// File: tb/tb_gpio_edge_irq.sv
module tb_gpio_edge_irq;

  localparam int DS   = 8;
  localparam int AW   = 16;
  localparam int BASE = 60003;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [AW-1:0] Addr = '0;
  logic          r_w = 1'b0;
  logic          write = 1'b0;
  logic [DS-1:0] PinIn = '0;
  logic          IRQ;
  tri1  [DS-1:0] Data;
  logic          tb_oe = 1'b0;
  logic [DS-1:0] tb_drv = '0;

  assign Data = tb_oe ? tb_drv : 'z;

  gpio_edge_irq #(.DataSize(DS), .BaseAddress(BASE)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .Addr    (Addr),
    .r_w     (r_w),
    .write   (write),
    .Data    (Data),
    .PinIn   (PinIn),
    .IRQ     (IRQ)
  );

  always #10 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: pins pass two sample stages; a pin's level moves to the
  // sampled value once that value has disagreed with the level for
  // DebounceCount+1 consecutive edges (streak taken modulo 256).
  logic [7:0] m_p1 = '0, m_p2 = '0, m_level = '0, m_status = '0;
  logic [7:0] m_en = '0, m_es = '0, m_dc = 8'd4;
  logic       m_irq = 1'b0;
  int         m_streak [8];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_p1 = '0; m_p2 = '0; m_level = '0; m_status = '0;
      m_en = '0; m_es = '0; m_dc = 8'd4; m_irq = 1'b0;
      for (int i = 0; i < 8; i++) m_streak[i] = 0;
    end else begin
      logic [7:0] evt, clr, nlev;
      logic       nirq;
      int         off;
      evt = '0; clr = '0; nlev = m_level;
      for (int i = 0; i < 8; i++) begin
        if (m_p2[i] == m_level[i]) begin
          m_streak[i] = 0;
        end else if ((m_streak[i] % 256) == int'(m_dc)) begin
          nlev[i] = m_p2[i];
          m_streak[i] = 0;
          if (m_p2[i] == m_es[i]) evt[i] = 1'b1;
        end else begin
          m_streak[i] = m_streak[i] + 1;
        end
      end
      nirq = |(m_status & m_en);
      off = int'(Addr) - BASE;
      if (write && r_w) begin
        case (off)
          0: clr  = tb_drv;
          1: m_en = tb_drv;
          2: m_es = tb_drv;
          3: m_dc = tb_drv;
          default: ;
        endcase
      end
      m_status = (m_status & ~clr) | evt;
      m_level  = nlev;
      m_p2     = m_p1;
      m_p1     = PinIn;
      m_irq    = nirq;
    end
  end

  function automatic logic [7:0] m_reg(input int off);
    case (off)
      0: return m_status;
      1: return m_en;
      2: return m_es;
      3: return m_dc;
      4: return m_level;
      default: return 8'hFF;  // undriven bus floats to the pull-up
    endcase
  endfunction

  task automatic rd(input int off, output logic [7:0] d);
    Addr = AW'(BASE + off);
    r_w  = 1'b0;
    #1;
    d = Data;
    Addr = '0;
  endtask

  task automatic chk_reg(input string tag, input int off, input logic [7:0] exp);
    logic [7:0] d;
    rd(off, d);
    chk(tag, {24'h0, d}, {24'h0, exp});
  endtask

  task automatic wr(input int off, input logic [7:0] d);
    Addr   = AW'(BASE + off);
    r_w    = 1'b1;
    write  = 1'b1;
    tb_oe  = 1'b1;
    tb_drv = d;
    @(negedge clk);
    write = 1'b0;
    tb_oe = 1'b0;
    r_w   = 1'b0;
    Addr  = '0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_irq"}, {31'h0, IRQ}, {31'h0, m_irq});
    chk_reg({tag, "_status"}, 0, m_status);
    chk_reg({tag, "_level"}, 4, m_level);
  endtask

  initial begin
    logic [7:0] d;
    cyc(3);
    // Reset values while reset is held
    chk("rst_irq", {31'h0, IRQ}, 32'h0);
    chk_reg("rst_status", 0, 8'h00);
    chk_reg("rst_enable", 1, 8'h00);
    chk_reg("rst_edgesel", 2, 8'h00);
    chk_reg("rst_dcount", 3, 8'h04);
    chk_reg("rst_level", 4, 8'h00);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Bypass debounce: Level/Status at E3, IRQ at E4
    wr(3, 8'h00); wr(2, 8'hFF); wr(1, 8'h01);
    PinIn = 8'h01;
    cyc(3);
    chk_reg("byp_level_e3", 4, 8'h01);
    chk_reg("byp_status_e3", 0, 8'h01);
    chk("byp_irq_e3", {31'h0, IRQ}, 32'h0);
    cyc(1);
    chk("byp_irq_e4", {31'h0, IRQ}, 32'h1);

    // Debounce 3: short glitch rejected, long pulse commits at E6
    wr(3, 8'h03);
    cyc(4);
    PinIn = 8'h05; cyc(2); PinIn = 8'h01;
    cyc(10);
    chk_reg("glitch_level", 4, 8'h01);
    chk_reg("glitch_status", 0, 8'h01);
    PinIn = 8'h05;
    cyc(5);
    chk_reg("pulse_level_e5", 4, 8'h01);
    cyc(1);
    chk_reg("pulse_level_e6", 4, 8'h05);
    chk_reg("pulse_status_e6", 0, 8'h05);
    PinIn = 8'h01;
    cyc(12);
    chk_model("pulse_end");

    // Falling edge select, W1C
    wr(0, 8'hFF);
    wr(2, 8'h00); wr(1, 8'h80);
    PinIn = 8'h81; cyc(12);
    chk_reg("fall_rise_level", 4, 8'h81);
    chk_reg("fall_rise_status", 0, 8'h00);
    PinIn = 8'h01; cyc(12);
    chk_reg("fall_status", 0, 8'h80);
    chk("fall_irq", {31'h0, IRQ}, 32'h1);
    wr(0, 8'h00);
    chk_reg("w0_status", 0, 8'h80);
    wr(0, 8'h80);
    chk_reg("w1c_status", 0, 8'h00);
    chk("w1c_irq_same", {31'h0, IRQ}, 32'h1);
    cyc(1);
    chk("w1c_irq_next", {31'h0, IRQ}, 32'h0);

    // Set beats clear in the same cycle
    wr(2, 8'h01); wr(1, 8'h01);
    PinIn = 8'h00; cyc(12);
    PinIn = 8'h01; cyc(12);
    chk_reg("coll_pre_status", 0, 8'h01);
    PinIn = 8'h00; cyc(12);
    PinIn = 8'h01;
    cyc(5);
    wr(0, 8'h01);
    chk_reg("coll_status", 0, 8'h01);
    chk_reg("coll_level", 4, 8'h01);
    chk("coll_irq", {31'h0, IRQ}, 32'h1);
    cyc(1);
    chk("coll_irq_next", {31'h0, IRQ}, 32'h1);
    chk_model("coll");

    // Read decode and read-only Level
    chk_reg("rd_level", 4, 8'h01);
    chk_reg("rd_base5_z", 5, 8'hFF);
    chk_reg("rd_basem1_z", -1, 8'hFF);
    wr(4, 8'hFE);
    chk_reg("wr_level_ign", 4, 8'h01);

    // Async reset mid-count with Status=FF
    wr(3, 8'h00); wr(2, 8'hFF); wr(1, 8'hFF);
    PinIn = 8'hFF; cyc(6);
    chk_reg("all_status", 0, 8'hFF);
    chk("all_irq", {31'h0, IRQ}, 32'h1);
    wr(3, 8'h05);
    PinIn = 8'h00; cyc(4);
    #3 reset_n = 1'b0;
    #1;
    chk("arst_irq", {31'h0, IRQ}, 32'h0);
    chk_reg("arst_status", 0, 8'h00);
    chk_reg("arst_enable", 1, 8'h00);
    chk_reg("arst_edgesel", 2, 8'h00);
    chk_reg("arst_dcount", 3, 8'h04);
    chk_reg("arst_level", 4, 8'h00);
    PinIn = 8'hA5;
    cyc(2);
    reset_n = 1'b1;
    cyc(1);

    // Randomized traffic against the model
    for (int it = 0; it < 800; it++) begin
      int r;
      chk("rnd_irq", {31'h0, IRQ}, {31'h0, m_irq});
      r = $urandom_range(0, 11);
      if (r <= 3) begin
        PinIn = PinIn ^ (8'h01 << $urandom_range(0, 7));
        @(negedge clk);
      end else if (r == 4) begin
        int off;
        off = $urandom_range(0, 6);
        if (off == 3) wr(off, 8'($urandom_range(0, 5)));
        else wr(off, 8'($urandom_range(0, 255)));
      end else if (r <= 6) begin
        int off;
        off = $urandom_range(0, 5);
        rd(off, d);
        chk("rnd_reg", {24'h0, d}, {24'h0, m_reg(off)});
        @(negedge clk);
      end else begin
        @(negedge clk);
      end
      if (it % 16 == 0) chk_model("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
